// File: rtl/ram_responder.sv
// Single-word RAM responder: programmable wait states, Busy/Ready handshake, out-of-range errors.
// Define RAM_PARITY_EN to add a per-word even-parity array that is checked on every read.
module ram_responder #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Enable,
  input  logic              RW,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] In,
  output logic [DATA_W-1:0] Out,
  output logic              Busy,
  output logic              Ready,
  output logic              Error
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS
  } state_t;

  state_t             state;
  logic [3:0]         cnt;
  logic               rw_q;
  logic               in_range_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DATA_W-1:0]  data_q;
  logic               wr_en;
  logic               par_err;

  logic [DATA_W-1:0]  mem [DEPTH];

  // Upper address bits only take part in the range check; the index uses the low bits.
  assign wr_en = (state == S_ACCESS) && rw_q && in_range_q;

  // NOTE: storage arrays carry no reset; a reset on a memory prevents RAM inference.
  always_ff @(posedge Clk) begin
    if (wr_en) mem[idx_q] <= data_q;
  end

`ifdef RAM_PARITY_EN
  logic par [DEPTH];

  always_ff @(posedge Clk) begin
    if (wr_en) par[idx_q] <= ^data_q;
  end

  assign par_err = (par[idx_q] != (^mem[idx_q]));
`else
  assign par_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      rw_q       <= 1'b0;
      in_range_q <= 1'b0;
      idx_q      <= '0;
      data_q     <= '0;
      Out        <= '0;
      Busy       <= 1'b0;
      Ready      <= 1'b0;
      Error      <= 1'b0;
    end else begin
      Ready <= 1'b0;
      Error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Enable) begin
            rw_q       <= RW;
            in_range_q <= ({1'b0, Address} < (ADDR_W+1)'(DEPTH));
            idx_q      <= Address[IDX_W-1:0];
            data_q     <= In;
            Busy       <= 1'b1;
            cnt        <= 4'(WAIT_STATES);
            state      <= (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) state <= S_ACCESS;
        end
        S_ACCESS: begin
          Busy  <= 1'b0;
          Ready <= 1'b1;
          state <= S_IDLE;
          if (!in_range_q) begin
            Error <= 1'b1;
          end else if (!rw_q) begin
            // A failed parity check still returns the raw stored word.
            Out   <= mem[idx_q];
            Error <= par_err;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder: one instance with one wait state, one with none.
// Expected responses are queued when a request is driven and popped when Ready arrives.
module tb_ram_responder;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;

  logic        en1, rw1;
  logic [15:0] addr1;
  logic [31:0] in1, out1;
  logic        busy1, ready1, err1;

  logic        en0, rw0;
  logic [15:0] addr0;
  logic [31:0] in0, out0;
  logic        busy0, ready0, err0;

  always #5 Clk = ~Clk;

  ram_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH(256), .WAIT_STATES(1)) dut (
    .Clk(Clk), .Reset(Reset), .Enable(en1), .RW(rw1), .Address(addr1), .In(in1),
    .Out(out1), .Busy(busy1), .Ready(ready1), .Error(err1)
  );

  ram_responder #(.ADDR_W(16), .DATA_W(32), .DEPTH(256), .WAIT_STATES(0)) dut0 (
    .Clk(Clk), .Reset(Reset), .Enable(en0), .RW(rw0), .Address(addr0), .In(in0),
    .Out(out0), .Busy(busy0), .Ready(ready0), .Error(err0)
  );

  typedef struct {
    logic [31:0] out;
    logic        err;
  } exp_t;

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [31:0] data;
    logic [31:0] exp_out;
    logic        exp_err;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[11];

  int total  = 0;
  int passed = 0;

  int readies, accepted, cyc, last_ready, extra;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'hA5A50000 ^ (32'(i) * 32'h01010101);
  endfunction

  // One request on the one-wait-state instance; response expected two edges after accept.
  task automatic req1(input logic rw, input logic [15:0] addr, input logic [31:0] data,
                      input logic [31:0] exp_out, input logic exp_err, input string tag);
    exp_t e;
    int   lat;
    @(negedge Clk);
    en1 = 1'b1; rw1 = rw; addr1 = addr; in1 = data;
    e.out = exp_out; e.err = exp_err;
    sb.push_back(e);
    @(negedge Clk);
    en1 = 1'b0;
    check({tag, " busy"}, 32'(busy1), 32'd1);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge Clk);
      if (ready1) lat = k;
    end
    check({tag, " latency"}, 32'(lat), 32'd2);
    e = sb.pop_front();
    check({tag, " out"}, out1, e.out);
    check({tag, " error"}, 32'(err1), 32'(e.err));
    check({tag, " busy_clr"}, 32'(busy1), 32'd0);
  endtask

  initial begin
    en1 = 0; rw1 = 0; addr1 = '0; in1 = '0;
    en0 = 0; rw0 = 0; addr0 = '0; in0 = '0;

    vecs[0]  = '{1'b1, 16'h0001, 32'hCCCC00AA, 32'h11111111, 1'b0};
    vecs[1]  = '{1'b0, 16'h0001, 32'h0,        32'hCCCC00AA, 1'b0};
    vecs[2]  = '{1'b1, 16'h00FF, 32'h12345678, 32'hCCCC00AA, 1'b0};
    vecs[3]  = '{1'b0, 16'h0100, 32'h0,        32'hCCCC00AA, 1'b1};
    vecs[4]  = '{1'b1, 16'h1234, 32'h55555555, 32'hCCCC00AA, 1'b1};
    vecs[5]  = '{1'b0, 16'h00FF, 32'h0,        32'h12345678, 1'b0};
    vecs[6]  = '{1'b1, 16'h0003, 32'h0000FFFF, 32'h12345678, 1'b0};
    vecs[7]  = '{1'b0, 16'h0003, 32'h0,        32'h0000FFFF, 1'b0};
    vecs[8]  = '{1'b0, 16'h0101, 32'h0,        32'h0000FFFF, 1'b1};
    vecs[9]  = '{1'b1, 16'h0201, 32'hBAD0BAD0, 32'h0000FFFF, 1'b1};
    vecs[10] = '{1'b0, 16'h0001, 32'h0,        32'hCCCC00AA, 1'b0};

    // Reset state
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    check("rst out", out1, 32'h0);
    check("rst busy", 32'(busy1), 32'd0);
    check("rst ready", 32'(ready1), 32'd0);
    check("rst error", 32'(err1), 32'd0);
    check("rst out0", out0, 32'h0);

    // Write aborted by reset in WAIT must not land
    req1(1'b1, 16'h0004, 32'h11111111, 32'h0, 1'b0, "pre_wr4");
    req1(1'b0, 16'h0004, 32'h0, 32'h11111111, 1'b0, "pre_rd4");
    @(negedge Clk);
    en1 = 1'b1; rw1 = 1'b1; addr1 = 16'h0004; in1 = 32'hDEADBEEF;
    @(negedge Clk);
    en1 = 1'b0;
    check("abort busy", 32'(busy1), 32'd1);
    Reset = 1'b1;
    #1;
    check("abort out", out1, 32'h0);
    check("abort busy_clr", 32'(busy1), 32'd0);
    check("abort ready", 32'(ready1), 32'd0);
    check("abort error", 32'(err1), 32'd0);
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    req1(1'b0, 16'h0004, 32'h0, 32'h11111111, 1'b0, "abort_rd4");

    // Table-driven vectors
    for (int i = 0; i < 11; i++)
      req1(vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].exp_out, vecs[i].exp_err,
           $sformatf("vec%0d", i));

    // Inputs changing while Busy are ignored
    begin
      exp_t e;
      int   lat;
      @(negedge Clk);
      en1 = 1'b1; rw1 = 1'b0; addr1 = 16'h0003; in1 = 32'h0;
      @(negedge Clk);
      en1 = 1'b0; rw1 = 1'b1; addr1 = 16'h00FF; in1 = 32'hFFFFFFFF;
      check("tog busy", 32'(busy1), 32'd1);
      @(negedge Clk);
      en1 = 1'b1; addr1 = 16'h0002;
      check("tog no_early_ready", 32'(ready1), 32'd0);
      lat = 0;
      for (int k = 1; k <= 20 && lat == 0; k++) begin
        @(negedge Clk);
        if (ready1) lat = k;
      end
      en1 = 1'b0;
      check("tog latency", 32'(lat), 32'd1);
      e.out = 32'h0000FFFF; e.err = 1'b0;
      check("tog out", out1, e.out);
      check("tog error", 32'(err1), 32'(e.err));
    end
    req1(1'b0, 16'h00FF, 32'h0, 32'h12345678, 1'b0, "tog_rdff");

    // Parity corruption on address 3
`ifdef RAM_PARITY_EN
    dut.par[3] = ~dut.par[3];
    req1(1'b0, 16'h0003, 32'h0, 32'h0000FFFF, 1'b1, "par_rd3");
`else
    req1(1'b0, 16'h0003, 32'h0, 32'h0000FFFF, 1'b0, "par_rd3");
`endif

    // Zero wait states: preload 0..16, then stream reads with Enable held high
    for (int i = 0; i <= 16; i++) begin
      int lat;
      @(negedge Clk);
      en0 = 1'b1; rw0 = 1'b1; addr0 = 16'(i); in0 = pat(i);
      @(negedge Clk);
      en0 = 1'b0;
      lat = ready0 ? 1 : 0;
      for (int k = 2; k <= 20 && lat == 0; k++) begin
        @(negedge Clk);
        if (ready0) lat = k;
      end
      if (i == 0) check("ws0 wr latency", 32'(lat), 32'd2);
    end
    check("ws0 wr out", out0, 32'h0);

    @(negedge Clk);
    en0 = 1'b1; rw0 = 1'b0; addr0 = 16'h0000;
    readies = 0; accepted = 0; cyc = 0; last_ready = 0;
    for (int c = 0; c < 100 && readies < 17; c++) begin
      @(negedge Clk);
      cyc++;
      if (ready0) begin
        if (sb.size() == 0) begin
          check("ws0 spurious ready", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check($sformatf("ws0 rd%0d out", readies), out0, e.out);
          check($sformatf("ws0 rd%0d error", readies), 32'(err0), 32'(e.err));
        end
        if (readies > 0) check($sformatf("ws0 rd%0d gap", readies), 32'(cyc - last_ready), 32'd2);
        last_ready = cyc;
        readies++;
      end
      if (busy0) begin
        exp_t e;
        e.out = pat(int'(addr0)); e.err = 1'b0;
        sb.push_back(e);
        accepted++;
        if (accepted == 17) en0 = 1'b0;
        else addr0 = addr0 + 16'd1;
      end
    end
    check("ws0 ready count", 32'(readies), 32'd17);
    check("ws0 accept count", 32'(accepted), 32'd17);
    extra = 0;
    repeat (4) begin
      @(negedge Clk);
      if (ready0 || busy0) extra++;
    end
    check("ws0 no extra", 32'(extra), 32'd0);
    check("sb empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
